// File: rtl/fdt_tx_scheduler.sv
// rtl/fdt_tx_scheduler.sv - schedules the PICC reply start on the FDT trigger or a later 128-tick slot
module fdt_tx_scheduler #(
  parameter int SLOT_TICKS      = 128,
  parameter int MAX_EXTRA_SLOTS = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     pause_n_synchronised,
  input  logic                                     rx_frame_done,
  input  logic                                     fdt_trigger,
  input  logic                                     tx_ready,
  input  logic                                     tx_done,
  output logic                                     tx_start,
  output logic                                     armed,
  output logic                                     timeout,
  output logic [$clog2(MAX_EXTRA_SLOTS+1)-1:0]     slot_idx
);

  localparam int TW = $clog2(SLOT_TICKS);
  localparam int SW = $clog2(MAX_EXTRA_SLOTS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SLOT_TICKS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(MAX_EXTRA_SLOTS);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SLOT_WAIT,
    TX
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] slot_q, slot_d, slot_next;
  logic [SW-1:0] slot_idx_d;
  logic          tx_start_d, timeout_d;
  logic          prev_pause_n;
  logic          pause_fall;
  logic          boundary;

  assign pause_fall = prev_pause_n & ~pause_n_synchronised;
  // Tick 0 is the first cycle after the trigger, so tick SLOT_TICKS-1 lands on T+k*SLOT_TICKS.
  assign boundary   = (tick_q == TICK_LAST);
  assign slot_next  = slot_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    slot_d     = slot_q;
    slot_idx_d = slot_idx;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_frame_done) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (pause_fall) begin
          state_d = IDLE;
        end else if (fdt_trigger) begin
          if (tx_ready) begin
            tx_start_d = 1'b1;
            slot_idx_d = '0;
            state_d    = TX;
          end else begin
            tick_d  = '0;
            slot_d  = '0;
            state_d = SLOT_WAIT;
          end
        end
      end
      SLOT_WAIT: begin
        // A new PCD frame beats a same-cycle boundary decision.
        if (pause_fall) begin
          state_d = IDLE;
        end else if (boundary) begin
          tick_d = '0;
          if (tx_ready) begin
            tx_start_d = 1'b1;
            slot_idx_d = slot_next;
            state_d    = TX;
          end else if (slot_next == SLOT_LAST) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            slot_d = slot_next;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      TX: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      slot_q       <= '0;
      prev_pause_n <= 1'b1;
      tx_start     <= 1'b0;
      timeout      <= 1'b0;
      armed        <= 1'b0;
      slot_idx     <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      slot_q       <= slot_d;
      prev_pause_n <= pause_n_synchronised;
      tx_start     <= tx_start_d;
      timeout      <= timeout_d;
      armed        <= (state_d == ARMED) || (state_d == SLOT_WAIT);
      slot_idx     <= slot_idx_d;
    end
  end

endmodule

// File: tb/tb_fdt_tx_scheduler.sv
// tb/tb_fdt_tx_scheduler.sv - scoreboard bench for fdt_tx_scheduler slot scheduling, aborts and timeout
module tb_fdt_tx_scheduler;

  localparam int ST = 128;
  localparam int MX = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause_n_synchronised = 1'b1;
  logic       rx_frame_done = 1'b0;
  logic       fdt_trigger = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic       armed;
  logic       timeout;
  logic [3:0] slot_idx;

  typedef struct {
    int unsigned cyc;
    bit          is_start;
    int unsigned slot;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned t_last = 0;
  int unsigned n_start = 0;

  fdt_tx_scheduler #(.SLOT_TICKS(ST), .MAX_EXTRA_SLOTS(MX)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pause_n_synchronised (pause_n_synchronised),
    .rx_frame_done        (rx_frame_done),
    .fdt_trigger          (fdt_trigger),
    .tx_ready             (tx_ready),
    .tx_done              (tx_done),
    .tx_start             (tx_start),
    .armed                (armed),
    .timeout              (timeout),
    .slot_idx             (slot_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Offset from the trigger cycle to the output pulse: first slot whose boundary sees tx_ready.
  function automatic int calc_k(input int rise);
    if (rise == 0) return 0;
    return (rise + ST - 1) / ST;
  endfunction

  function automatic int calc_e(input int rise);
    int k;
    k = calc_k(rise);
    return (k > MX) ? (MX * ST + 1) : (k * ST + 1);
  endfunction

  always @(negedge clk) begin
    if (tx_start === 1'b1 || timeout === 1'b1) begin
      chk("start_timeout_exclusive", {63'd0, tx_start & timeout}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", {62'd0, tx_start, timeout}, 64'd0);
      end else begin
        ev_t ev;
        ev = sb.pop_front();
        chk("event_kind_is_start", {63'd0, tx_start}, {63'd0, ev.is_start});
        chk("event_cycle", cyc, ev.cyc);
        if (tx_start) chk("event_slot_idx", slot_idx, ev.slot);
      end
      if (tx_start) begin
        n_start++;
        chk("start_on_slot_grid", (cyc - t_last - 1) % ST, 0);
        chk("slot_idx_from_offset", slot_idx, (cyc - t_last - 1) / ST);
      end
    end
  end

  task automatic run_txn(input int rise, input bit use_p, input int p,
                         input bit use_r, input int r, input int lim_extra);
    int  k, e, lim;
    bit  to, abort, lost, exp_armed;
    ev_t ev;
    @(negedge clk);
    rx_frame_done = 1'b1;
    @(negedge clk);
    rx_frame_done = 1'b0;
    chk("armed_after_rx", {63'd0, armed}, 64'd1);
    @(negedge clk);
    k     = calc_k(rise);
    to    = (k > MX);
    e     = calc_e(rise);
    lim   = e + lim_extra;
    abort = use_p && (p == 0 || (k > 0 && p <= e - 1));
    lost  = use_r && (r < e);
    exp_armed = !(use_p && p <= e - 2 && (p == 0 || k > 0)) && !(use_r && r <= e - 2);
    t_last = cyc;
    if (!abort && !lost) begin
      ev.cyc      = cyc + e;
      ev.is_start = !to;
      ev.slot     = to ? 0 : k;
      sb.push_back(ev);
    end
    for (int o = 0; o <= lim; o++) begin
      if (o > 0) @(negedge clk);
      if (o == e - 1) chk("armed_before_decision", {63'd0, armed}, {63'd0, exp_armed});
      fdt_trigger          = (o == 0);
      tx_ready             = (o >= rise);
      pause_n_synchronised = !(use_p && o >= p && o < p + 3);
      rst                  = use_r && o >= r && o < r + 2;
      tx_done              = (o == lim);
    end
    @(negedge clk);
    tx_done = 1'b0; tx_ready = 1'b0; fdt_trigger = 1'b0;
    pause_n_synchronised = 1'b1; rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("armed_low_after_txn", {63'd0, armed}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned starts_before;
    int rise, p, r, e;
    bit use_p, use_r;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_tx_start", {63'd0, tx_start}, 64'd0);
    chk("reset_timeout", {63'd0, timeout}, 64'd0);
    chk("reset_armed", {63'd0, armed}, 64'd0);
    chk("reset_slot_idx", slot_idx, 64'd0);
    rst = 1'b0;

    // Trigger with no received frame must be ignored.
    @(negedge clk);
    starts_before = n_start;
    tx_ready = 1'b1; fdt_trigger = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    fdt_trigger = 1'b0; tx_done = 1'b0;
    repeat (3000) @(negedge clk);
    chk("idle_trigger_no_start", n_start - starts_before, 0);
    chk("idle_trigger_armed", {63'd0, armed}, 64'd0);
    tx_ready = 1'b0;

    run_txn(0, 1'b0, 0, 1'b0, 0, 199);
    run_txn(300, 1'b0, 0, 1'b0, 0, 15);
    chk("slot_idx_holds_after_tx", slot_idx, 64'd3);
    run_txn(2000, 1'b0, 0, 1'b0, 0, 5);
    chk("slot_idx_holds_after_timeout", slot_idx, 64'd3);
    run_txn(200, 1'b1, 256, 1'b0, 0, 143);
    run_txn(0, 1'b1, 0, 1'b0, 0, 50);
    chk("slot_idx_holds_after_abort", slot_idx, 64'd3);

    for (int it = 0; it < 45; it++) begin
      rise  = int'($urandom_range(1500, 0));
      e     = calc_e(rise);
      use_p = ($urandom_range(3, 0) == 0);
      use_r = ($urandom_range(4, 0) == 0);
      p     = int'($urandom_range(e + 2, 1));
      r     = int'($urandom_range(e + 2, 1));
      run_txn(rise, use_p, p, use_r, r, 4);
    end

    chk("final_scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
